// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - glyphs, FSM states and sizing helpers for the seven-segment display engine
package seg_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b0000001;
   localparam logic [6:0] SEG_E     = 7'b1001111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_FORMAT  = 2'd3
   } state_t;

   // Segment order is a..g on bits 6..0, active high.
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0: g = 7'b1111110;
         4'd1: g = 7'b0110000;
         4'd2: g = 7'b1101101;
         4'd3: g = 7'b1111001;
         4'd4: g = 7'b0110011;
         4'd5: g = 7'b1011011;
         4'd6: g = 7'b1011111;
         4'd7: g = 7'b1110000;
         4'd8: g = 7'b1111111;
         4'd9: g = 7'b1111011;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

   // ceil(width * log10(2)) in fixed point.
   function automatic int bcd_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

   function automatic int dec_digits(input int n);
      int c;
      int v;
      c = 1;
      v = n;
      for (int i = 0; i < 10; i++) begin
         if (v >= 10) begin
            v = v / 10;
            c = c + 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/seg_display_engine_bcd.sv
// rtl/seg_display_engine_bcd.sv - sequential double-dabble binary to BCD converter
module bcd_seq_converter
   import seg_display_pkg::*;
#(
   parameter int DATA_W     = 30,
   parameter int BCD_DIGITS = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    capture,
   input  logic                    shift_en,
   input  logic [DATA_W-1:0]       value,
   input  logic                    signed_mode,
   output logic [4*BCD_DIGITS-1:0] bcd,
   output logic                    neg,
   output logic                    done
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0]       bin_q, bin_d;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic                    neg_q, neg_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    is_neg;

   always_comb begin
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      bcd_adj = bcd_q;
      is_neg  = signed_mode & value[DATA_W-1];
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      if (capture) begin
         bin_d = is_neg ? (~value + 1'b1) : value;
         neg_d = is_neg;
         bcd_d = '0;
         cnt_d = '0;
      end else if (shift_en) begin
         bcd_d = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[DATA_W-1]};
         bin_d = {bin_q[DATA_W-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
         neg_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         neg_q <= neg_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd  = bcd_q;
   assign neg  = neg_q;
   assign done = shift_en && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/seg_display_engine.sv
// rtl/seg_display_engine.sv - binary result to multiplexed seven-segment display with sign and scientific formatting
module seg_display_engine
   import seg_display_pkg::*;
#(
   parameter int DATA_W      = 30,
   parameter int NUM_DIGITS  = 8,
   parameter int SOURCE_FREQ = 100000000,
   parameter int TARGET_FREQ = 400,
   parameter int LZ_BLANK    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     value,
   input  logic                  signed_mode,
   input  logic                  load,
   input  logic                  show,
   input  logic                  blank,
   output logic                  busy,
   output logic [6:0]            segments,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic                  DP
);

   localparam int BCD_DIGITS = bcd_digits(DATA_W);
   localparam int EXP_DIGITS = dec_digits(BCD_DIGITS - 1);
   localparam int DIV        = SOURCE_FREQ / TARGET_FREQ;
   localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   state_t                         state_q, state_d;
   logic [DATA_W-1:0]              value_q, value_d;
   logic                           smode_q, smode_d;
   logic [NUM_DIGITS-1:0][6:0]     frame_seg_q, frame_seg_d, fmt_seg;
   logic [NUM_DIGITS-1:0]          frame_dp_q, frame_dp_d, fmt_dp;
   logic                           frame_valid_q, frame_valid_d;
   logic                           disp_on_q, disp_on_d;
   logic [DIV_W-1:0]               div_q, div_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [6:0]                     segments_q, segments_d;
   logic [NUM_DIGITS-1:0]          anodes_q, anodes_d;
   logic                           dp_q, dp_d;

   logic [4*BCD_DIGITS-1:0]        conv_bcd;
   logic                           conv_neg;
   logic                           conv_done;
   logic [4*EXP_DIGITS-1:0]        exp_bcd;

   bcd_seq_converter #(
      .DATA_W     (DATA_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_conv (
      .clk         (clk),
      .rst         (rst),
      .capture     (state_q == ST_CAPTURE),
      .shift_en    (state_q == ST_SHIFT),
      .value       (value_q),
      .signed_mode (smode_q),
      .bcd         (conv_bcd),
      .neg         (conv_neg),
      .done        (conv_done)
   );

   // Frame formatter: plain right-aligned decimal, or mantissa/E/exponent when it will not fit.
   always_comb begin
      int         sig;
      int         avail;
      int         e;
      int         mant_idx;
      logic [3:0] d_sel;
      fmt_seg  = '0;
      fmt_dp   = '0;
      exp_bcd  = '0;
      sig      = 1;
      mant_idx = 0;
      d_sel    = '0;
      avail    = NUM_DIGITS - (conv_neg ? 1 : 0);
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (conv_bcd[4*d +: 4] != 4'd0) sig = d + 1;
      end
      e = sig - 1;
      for (int j = 0; j < EXP_DIGITS; j++) begin
         exp_bcd[4*j +: 4] = 4'(e % 10);
         e = e / 10;
      end
      for (int p = 0; p < NUM_DIGITS; p++) begin
         d_sel = '0;
         if (sig <= avail) begin
            if (p < sig) begin
               for (int d = 0; d < BCD_DIGITS; d++) begin
                  if (d == p) d_sel = conv_bcd[4*d +: 4];
               end
               fmt_seg[p] = digit_glyph(d_sel);
            end else if (conv_neg && p == sig) begin
               fmt_seg[p] = SEG_MINUS;
            end else if (LZ_BLANK == 0) begin
               fmt_seg[p] = digit_glyph(4'd0);
            end
         end else begin
            if (conv_neg && p == NUM_DIGITS - 1) begin
               fmt_seg[p] = SEG_MINUS;
            end else if (p > EXP_DIGITS) begin
               mant_idx = sig - avail + p;
               for (int d = 0; d < BCD_DIGITS; d++) begin
                  if (d == mant_idx) d_sel = conv_bcd[4*d +: 4];
               end
               fmt_seg[p] = digit_glyph(d_sel);
               fmt_dp[p]  = (p == avail - 1);
            end else if (p == EXP_DIGITS) begin
               fmt_seg[p] = SEG_E;
            end else begin
               for (int j = 0; j < EXP_DIGITS; j++) begin
                  if (j == p) d_sel = exp_bcd[4*j +: 4];
               end
               fmt_seg[p] = digit_glyph(d_sel);
            end
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      value_d       = value_q;
      smode_d       = smode_q;
      frame_seg_d   = frame_seg_q;
      frame_dp_d    = frame_dp_q;
      frame_valid_d = frame_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d = ST_CAPTURE;
               value_d = value;
               smode_d = signed_mode;
            end
         end
         ST_CAPTURE: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (conv_done) state_d = ST_FORMAT;
         end
         ST_FORMAT: begin
            state_d       = ST_IDLE;
            frame_seg_d   = fmt_seg;
            frame_dp_d    = fmt_dp;
            frame_valid_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      disp_on_d = disp_on_q;
      if (blank) begin
         disp_on_d = 1'b0;
      end else if (show) begin
         disp_on_d = 1'b1;
      end
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == DIV_W'(DIV - 1)) begin
         div_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      // Scan keeps running while dark so re-enabling resumes mid-cycle without a glitch.
      if (disp_on_q && frame_valid_q) begin
         anodes_d   = ~(NUM_DIGITS'(1) << idx_q);
         segments_d = frame_seg_q[idx_q];
         dp_d       = ~frame_dp_q[idx_q];
      end else begin
         anodes_d   = '1;
         segments_d = SEG_BLANK;
         dp_d       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         value_q       <= '0;
         smode_q       <= 1'b0;
         frame_seg_q   <= '0;
         frame_dp_q    <= '0;
         frame_valid_q <= 1'b0;
         disp_on_q     <= 1'b0;
         div_q         <= '0;
         idx_q         <= '0;
         segments_q    <= SEG_BLANK;
         anodes_q      <= '1;
         dp_q          <= 1'b1;
      end else begin
         state_q       <= state_d;
         value_q       <= value_d;
         smode_q       <= smode_d;
         frame_seg_q   <= frame_seg_d;
         frame_dp_q    <= frame_dp_d;
         frame_valid_q <= frame_valid_d;
         disp_on_q     <= disp_on_d;
         div_q         <= div_d;
         idx_q         <= idx_d;
         segments_q    <= segments_d;
         anodes_q      <= anodes_d;
         dp_q          <= dp_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign segments = segments_q;
   assign anodes   = anodes_q;
   assign DP       = dp_q;

endmodule

// File: tb/tb_seg_display_engine.sv
// tb/tb_seg_display_engine.sv - directed self-checking bench for seg_display_engine
module tb_seg_display_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] value = '0;
   logic        signed_mode = 1'b0;
   logic        load = 1'b0;
   logic        show = 1'b0;
   logic        blank = 1'b0;
   logic        busy;
   logic [6:0]  segments;
   logic [7:0]  anodes;
   logic        DP;

   int checks = 0;
   int errors = 0;

   logic [6:0] seen_seg [8];
   logic       seen_dp  [8];
   int         seen_cnt [8];
   int         bad_step;
   logic [6:0] exp_seg  [8];
   logic       exp_dp   [8];

   seg_display_engine #(
      .DATA_W      (30),
      .NUM_DIGITS  (8),
      .SOURCE_FREQ (40),
      .TARGET_FREQ (10),
      .LZ_BLANK    (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .signed_mode (signed_mode),
      .load        (load),
      .show        (show),
      .blank       (blank),
      .busy        (busy),
      .segments    (segments),
      .anodes      (anodes),
      .DP          (DP)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Codes: 0-9 digit, 10 blank, 11 minus, 12 E.
   function automatic logic [6:0] code_seg(input int c);
      case (c)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         11: return 7'b0000001;
         12: return 7'b1001111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Listed most significant digit first.
   task automatic set_digits(input int d [8], input logic dp7);
      for (int k = 0; k < 8; k++) begin
         exp_seg[7-k] = code_seg(d[k]);
         exp_dp[7-k]  = 1'b1;
      end
      exp_dp[7] = dp7;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load(input logic [29:0] v, input logic sm);
      value = v;
      signed_mode = sm;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic pulse_show();
      show = 1'b1;
      @(negedge clk);
      show = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
      end
   endtask

   task automatic grab();
      int prev;
      prev = -1;
      bad_step = 0;
      for (int i = 0; i < 8; i++) begin
         seen_cnt[i] = 0;
         seen_seg[i] = 7'bx;
         seen_dp[i]  = 1'bx;
      end
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            if (anodes === ~(8'b1 << i)) begin
               seen_seg[i] = segments;
               seen_dp[i]  = DP;
               seen_cnt[i]++;
               if (prev >= 0 && i != prev && i != (prev + 1) % 8) bad_step++;
               prev = i;
            end
         end
      end
   endtask

   task automatic test_reset();
      cycles(3);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (segments !== 7'b0) begin errors++; $display("FAIL reset_segments: got %b want 0000000", segments); end
      checks++;
      if (anodes !== 8'hFF) begin errors++; $display("FAIL reset_anodes: got %b want 11111111", anodes); end
      checks++;
      if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", DP); end
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic test_zero();
      pulse_load(30'd0, 1'b0);
      wait_idle();
      pulse_show();
      cycles(2);
      grab();
      set_digits('{10, 10, 10, 10, 10, 10, 10, 0}, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_cnt[i] !== 4 || seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL zero_digit%0d: seg %b dp %b dwell %0d, want seg %b dp %b dwell 4",
                     i, seen_seg[i], seen_dp[i], seen_cnt[i], exp_seg[i], exp_dp[i]);
         end
      end
      checks++;
      if (bad_step !== 0) begin errors++; $display("FAIL zero_scan_order: %0d bad steps, want 0", bad_step); end
   endtask

   task automatic test_plain();
      int n;
      pulse_load(30'd12345678, 1'b0);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 32) begin errors++; $display("FAIL plain_busy_len: got %0d cycles want 32", n); end
      pulse_load(30'd12345678, 1'b0);
      cycles(4);
      pulse_load(30'd99, 1'b0);
      wait_idle();
      cycles(2);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL plain_drop_busy: got %b want 0", busy); end
      grab();
      set_digits('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL plain_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   task automatic test_scientific();
      pulse_load(30'd123456789, 1'b0);
      wait_idle();
      cycles(2);
      grab();
      set_digits('{1, 2, 3, 4, 5, 6, 12, 8}, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL sci9_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
      pulse_load(30'd1000000000, 1'b0);
      wait_idle();
      cycles(2);
      grab();
      set_digits('{1, 0, 0, 0, 0, 0, 12, 9}, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL sci10_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   task automatic test_signed();
      pulse_load(30'h3FFFFFD6, 1'b1);
      wait_idle();
      cycles(2);
      grab();
      set_digits('{10, 10, 10, 10, 10, 11, 4, 2}, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL signed_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
      pulse_load(30'h3FFFFFD6, 1'b0);
      wait_idle();
      cycles(2);
      grab();
      set_digits('{1, 0, 7, 3, 7, 4, 12, 9}, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL unsigned_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   task automatic test_enable();
      int dark_bad;
      int old_bad;
      blank = 1'b1;
      @(negedge clk);
      show = 1'b1;
      @(negedge clk);
      show = 1'b0;
      blank = 1'b0;
      dark_bad = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (anodes !== 8'hFF || segments !== 7'b0 || DP !== 1'b1) dark_bad++;
      end
      checks++;
      if (dark_bad !== 0) begin errors++; $display("FAIL enable_blank_wins: %0d lit samples, want 0", dark_bad); end
      pulse_show();
      cycles(2);
      grab();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL enable_on_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
      pulse_load(30'd42, 1'b0);
      old_bad = 0;
      for (int c = 0; c < 40 && busy; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (anodes === ~(8'b1 << i) && segments !== exp_seg[i]) old_bad++;
         end
         if (anodes === 8'hFF) old_bad++;
         @(negedge clk);
      end
      checks++;
      if (old_bad !== 0) begin errors++; $display("FAIL enable_old_frame: %0d bad samples during busy, want 0", old_bad); end
      wait_idle();
      cycles(2);
      grab();
      set_digits('{10, 10, 10, 10, 10, 10, 4, 2}, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL enable_new_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   task automatic test_rst_mid();
      pulse_load(30'd12345678, 1'b0);
      cycles(9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      checks++;
      if (anodes !== 8'hFF) begin errors++; $display("FAIL rst_mid_anodes: got %b want 11111111", anodes); end
      checks++;
      if (segments !== 7'b0) begin errors++; $display("FAIL rst_mid_segments: got %b want 0000000", segments); end
      pulse_show();
      cycles(3);
      checks++;
      if (anodes !== 8'hFF) begin errors++; $display("FAIL rst_mid_no_frame: anodes %b want 11111111", anodes); end
      pulse_load(30'd7, 1'b0);
      wait_idle();
      cycles(2);
      grab();
      set_digits('{10, 10, 10, 10, 10, 10, 10, 7}, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seen_seg[i] !== exp_seg[i] || seen_dp[i] !== exp_dp[i]) begin
            errors++;
            $display("FAIL rst_mid_digit%0d: seg %b dp %b, want seg %b dp %b",
                     i, seen_seg[i], seen_dp[i], exp_seg[i], exp_dp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_plain();
      test_scientific();
      test_signed();
      test_enable();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
